// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with one write port, two
// combinational read ports, optional hardwired zero register and a clear
// sequencer that zeroes every entry after reset.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : same-cycle write-through forwarding to the read ports in RUN
//   undefined : read ports return the pre-edge memory contents
//
// Ports:
//   clk              - clock, all state changes on the rising edge
//   reset            - synchronous active-high reset, restarts the clear
//   RegWrite_control - write enable
//   Write_reg        - write address
//   Write_data       - write data
//   Read_register1/2 - read addresses
//   Read_data1/2     - combinational read data (0 while clearing)
//   ready            - registered, high once the clear sequence is done
//   wr_dropped       - registered pulse, a write was ignored while clearing
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite_control,
  input  logic [ADDR_W-1:0] Write_reg,
  input  logic [DATA_W-1:0] Write_data,
  input  logic [ADDR_W-1:0] Read_register1,
  input  logic [ADDR_W-1:0] Read_register2,
  output logic [DATA_W-1:0] Read_data1,
  output logic [DATA_W-1:0] Read_data2,
  output logic              ready,
  output logic              wr_dropped
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam bit          ZERO_EN = (ZERO_REG != 0);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              ready_q, ready_d;
  logic              wr_dropped_q, wr_dropped_d;

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] rd1_c;
  logic [DATA_W-1:0] rd2_c;

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      clr_idx_q    <= '0;
      ready_q      <= 1'b0;
      wr_dropped_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      ready_q      <= ready_d;
      wr_dropped_q <= wr_dropped_d;
    end
  end

  // Next-state logic and memory write-port steering
  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    ready_d      = ready_q;
    wr_dropped_d = 1'b0;
    mem_we_c     = 1'b0;
    mem_waddr_c  = Write_reg;
    mem_wdata_c  = Write_data;

    case (state_q)
      ST_INIT: begin
        // The clear sequencer owns the write port; user writes are dropped.
        mem_we_c     = 1'b1;
        mem_waddr_c  = clr_idx_q;
        mem_wdata_c  = '0;
        clr_idx_d    = clr_idx_q + ADDR_W'(1);
        wr_dropped_d = RegWrite_control;
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        // Writes to the hardwired zero register vanish without a drop pulse.
        mem_we_c = RegWrite_control && !(ZERO_EN && (Write_reg == '0));
      end
      default: begin
        state_d = ST_INIT;
        ready_d = 1'b0;
      end
    endcase
  end

  // Storage array; no reset, contents are zeroed by the clear sequencer
  always_ff @(posedge clk) begin
    if (!reset && mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Read port 1: zero rule beats forwarding, nothing visible while clearing
  always_comb begin
    rd1_c = mem_q[Read_register1];
`ifdef REGFILE_BYPASS_EN
    if (RegWrite_control && (Write_reg == Read_register1)) begin
      rd1_c = Write_data;
    end
`endif
    if ((state_q != ST_RUN) || (ZERO_EN && (Read_register1 == '0))) begin
      rd1_c = '0;
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    rd2_c = mem_q[Read_register2];
`ifdef REGFILE_BYPASS_EN
    if (RegWrite_control && (Write_reg == Read_register2)) begin
      rd2_c = Write_data;
    end
`endif
    if ((state_q != ST_RUN) || (ZERO_EN && (Read_register2 == '0))) begin
      rd2_c = '0;
    end
  end

  assign Read_data1 = rd1_c;
  assign Read_data2 = rd2_c;
  assign ready      = ready_q;
  assign wr_dropped = wr_dropped_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: three instances (default, ZERO_REG=0, and
// DATA_W=64/ADDR_W=3) driven side by side against a behavioural model that
// tracks cycles-since-reset and an array of register values.
module tb_regfile_mp;

  logic clk;

  logic        rst [3];
  logic        we  [3];
  logic [4:0]  wa  [3];
  logic [4:0]  ra1 [3];
  logic [4:0]  ra2 [3];
  logic [63:0] wd  [3];

  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic [63:0] c_rd1, c_rd2;
  logic        rdy [3];
  logic        drp [3];
  logic [63:0] rd1 [3];
  logic [63:0] rd2 [3];

  assign rd1[0] = {32'h0, a_rd1};
  assign rd2[0] = {32'h0, a_rd2};
  assign rd1[1] = {32'h0, b_rd1};
  assign rd2[1] = {32'h0, b_rd2};
  assign rd1[2] = c_rd1;
  assign rd2[2] = c_rd2;

  // Per-instance configuration
  int          depth [3] = '{32, 32, 8};
  bit          zero  [3] = '{1'b1, 1'b0, 1'b1};
  logic [63:0] msk   [3] = '{64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

`ifdef REGFILE_BYPASS_EN
  localparam logic [63:0] SAME_EXP = 64'h22;
`else
  localparam logic [63:0] SAME_EXP = 64'h11;
`endif

  // Reference model state
  logic [63:0] m [3][32];
  int          cnt [3];
  logic        e_drop [3];

  int n_chk  = 0;
  int n_pass = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_a (
    .clk(clk), .reset(rst[0]), .RegWrite_control(we[0]), .Write_reg(wa[0]),
    .Write_data(wd[0][31:0]), .Read_register1(ra1[0]), .Read_register2(ra2[0]),
    .Read_data1(a_rd1), .Read_data2(a_rd2), .ready(rdy[0]), .wr_dropped(drp[0])
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_b (
    .clk(clk), .reset(rst[1]), .RegWrite_control(we[1]), .Write_reg(wa[1]),
    .Write_data(wd[1][31:0]), .Read_register1(ra1[1]), .Read_register2(ra2[1]),
    .Read_data1(b_rd1), .Read_data2(b_rd2), .ready(rdy[1]), .wr_dropped(drp[1])
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(1)) u_c (
    .clk(clk), .reset(rst[2]), .RegWrite_control(we[2]), .Write_reg(wa[2][2:0]),
    .Write_data(wd[2]), .Read_register1(ra1[2][2:0]), .Read_register2(ra2[2][2:0]),
    .Read_data1(c_rd1), .Read_data2(c_rd2), .ready(rdy[2]), .wr_dropped(drp[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ready is a pure function of non-reset edges seen since the last reset
  function automatic bit e_ready(int k);
    return cnt[k] >= depth[k];
  endfunction

  // Expected combinational read value given the current inputs
  function automatic logic [63:0] exp_rd(int k, logic [4:0] a);
    if (!e_ready(k)) return 64'h0;
    if (zero[k] && a == 5'd0) return 64'h0;
`ifdef REGFILE_BYPASS_EN
    if (we[k] && wa[k] == a) return wd[k] & msk[k];
`endif
    return m[k][a];
  endfunction

  // Advance one rising edge, updating the model from the pre-edge inputs
  task automatic tick();
    for (int k = 0; k < 3; k++) begin
      if (rst[k]) begin
        cnt[k]    = 0;
        e_drop[k] = 1'b0;
        for (int a = 0; a < 32; a++) m[k][a] = 64'h0;
      end else if (cnt[k] < depth[k]) begin
        cnt[k]    = cnt[k] + 1;
        e_drop[k] = we[k];
      end else begin
        e_drop[k] = 1'b0;
        if (we[k] && !(zero[k] && wa[k] == 5'd0)) m[k][wa[k]] = wd[k] & msk[k];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0;
      we[k]  = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    idle();
    while (!(rdy[0] && rdy[1] && rdy[2]) && n < 100) begin
      tick();
      n++;
    end
    n_chk++;
    if (!(rdy[0] && rdy[1] && rdy[2]))
      $display("FAIL wait_ready: ready=%b%b%b after %0d cycles, required 111", rdy[0], rdy[1], rdy[2], n);
    else n_pass++;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      we[k]  = 1'b0;
      ra1[k] = 5'($urandom % depth[k]);
      ra2[k] = 5'($urandom % depth[k]);
    end
    tick();
    idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (rdy[k] !== 1'b0) $display("FAIL reset_ready[%0d]: got %b required 0", k, rdy[k]);
      else n_pass++;
      n_chk++;
      if (drp[k] !== 1'b0) $display("FAIL reset_wr_dropped[%0d]: got %b required 0", k, drp[k]);
      else n_pass++;
      n_chk++;
      if (rd1[k] !== 64'h0) $display("FAIL reset_rd1[%0d]: got %h required 0", k, rd1[k]);
      else n_pass++;
      n_chk++;
      if (rd2[k] !== 64'h0) $display("FAIL reset_rd2[%0d]: got %h required 0", k, rd2[k]);
      else n_pass++;
    end
  endtask

  task automatic test_clear_sequence();
    int first [3];
    wait_ready();
    for (int a = 0; a < 32; a++) begin
      for (int k = 0; k < 3; k++) begin
        we[k] = 1'b1;
        wa[k] = 5'(a % depth[k]);
        wd[k] = (k == 2) ? 64'hDEAD_BEEF_DEAD_BEEF : 64'h0000_0000_DEAD_BEEF;
      end
      tick();
    end
    idle();
    for (int k = 0; k < 3; k++) ra1[k] = 5'd3;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (rd1[k] !== exp_rd(k, ra1[k])) $display("FAIL preload_rd[%0d]: got %h required %h", k, rd1[k], exp_rd(k, ra1[k]));
      else n_pass++;
    end
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 3; k++) first[k] = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (rdy[k] !== e_ready(k)) $display("FAIL clear_ready[%0d] cycle %0d: got %b required %b", k, n, rdy[k], e_ready(k));
        else n_pass++;
        if (rdy[k] === 1'b1 && first[k] < 0) first[k] = n;
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (first[k] != depth[k]) $display("FAIL clear_latency[%0d]: got %0d required %0d", k, first[k], depth[k]);
      else n_pass++;
    end
    for (int a = 0; a < 32; a++) begin
      for (int k = 0; k < 3; k++) begin
        ra1[k] = 5'(a % depth[k]);
        ra2[k] = 5'((31 - a) % depth[k]);
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (rd1[k] !== 64'h0 || rd2[k] !== 64'h0)
          $display("FAIL cleared_rd[%0d] addr %0d/%0d: got %h/%h required 0/0", k, ra1[k], ra2[k], rd1[k], rd2[k]);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_basic();
    logic [63:0] v1, v2;
    v1 = {$urandom, $urandom};
    v1[63] = 1'b1;
    v1[0]  = 1'b1;
    v2 = ~v1;
    idle();
    for (int k = 0; k < 3; k++) we[k] = 1'b1;
    wa[0] = 5'd5;  wd[0] = 64'h1234_5678;
    wa[1] = 5'd5;  wd[1] = 64'h1234_5678;
    wa[2] = 5'd5;  wd[2] = v1;
    tick();
    wa[0] = 5'd31; wd[0] = 64'hCAFE_F00D;
    wa[1] = 5'd31; wd[1] = 64'hCAFE_F00D;
    wa[2] = 5'd7;  wd[2] = v2;
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      ra1[k] = 5'd5;
      ra2[k] = (k == 2) ? 5'd7 : 5'd31;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (rd1[k] !== 64'h1234_5678) $display("FAIL basic_r5[%0d]: got %h required 12345678", k, rd1[k]);
      else n_pass++;
      n_chk++;
      if (rd2[k] !== 64'hCAFE_F00D) $display("FAIL basic_r31[%0d]: got %h required cafef00d", k, rd2[k]);
      else n_pass++;
    end
    n_chk++;
    if (rd1[2] !== v1) $display("FAIL basic64_r5: got %h required %h", rd1[2], v1);
    else n_pass++;
    n_chk++;
    if (rd2[2] !== v2) $display("FAIL basic64_r7: got %h required %h", rd2[2], v2);
    else n_pass++;
    tick();
  endtask

  task automatic test_zero_reg();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0;
      we[k]  = 1'b1;
      wa[k]  = 5'd0;
      wd[k]  = msk[k];
      ra1[k] = 5'd0;
      ra2[k] = 5'd0;
    end
    #1;
    n_chk++;
    if (rd1[0] !== 64'h0) $display("FAIL zero_write_cycle: got %h required 0", rd1[0]);
    else n_pass++;
    tick();
    idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (drp[k] !== 1'b0) $display("FAIL zero_wr_dropped[%0d]: got %b required 0", k, drp[k]);
      else n_pass++;
    end
    for (int k = 0; k < 3; k += 2) begin
      n_chk++;
      if (rd1[k] !== 64'h0 || rd2[k] !== 64'h0) $display("FAIL zero_rd[%0d]: got %h/%h required 0/0", k, rd1[k], rd2[k]);
      else n_pass++;
    end
    n_chk++;
    if (rd1[1] !== 64'hFFFF_FFFF || rd2[1] !== 64'hFFFF_FFFF)
      $display("FAIL nozero_rd: got %h/%h required ffffffff/ffffffff", rd1[1], rd2[1]);
    else n_pass++;
    tick();
  endtask

  task automatic test_init_drop();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      we[k]  = 1'b0;
    end
    tick();
    idle();
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      we[k]  = 1'b1;
      wa[k]  = 5'd7;
      wd[k]  = (k == 2) ? 64'hAAAA_5555_AAAA_5555 : 64'hAAAA_5555;
      ra1[k] = 5'd7;
    end
    tick();
    idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (drp[k] !== 1'b1) $display("FAIL init_drop_pulse[%0d]: got %b required 1", k, drp[k]);
      else n_pass++;
      n_chk++;
      if (rdy[k] !== 1'b0) $display("FAIL init_drop_ready[%0d]: got %b required 0", k, rdy[k]);
      else n_pass++;
      n_chk++;
      if (rd1[k] !== 64'h0) $display("FAIL init_read_zero[%0d]: got %h required 0", k, rd1[k]);
      else n_pass++;
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (drp[k] !== 1'b0) $display("FAIL init_drop_single[%0d]: got %b required 0", k, drp[k]);
      else n_pass++;
    end
    wait_ready();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (rd1[k] !== 64'h0) $display("FAIL init_drop_r7[%0d]: got %h required 0", k, rd1[k]);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_same_cycle();
    idle();
    for (int k = 0; k < 2; k++) begin
      we[k] = 1'b1;
      wa[k] = 5'd9;
      wd[k] = 64'h11;
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      wd[k]  = 64'h22;
      ra1[k] = 5'd9;
      ra2[k] = 5'd9;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (rd1[k] !== SAME_EXP || rd2[k] !== SAME_EXP)
        $display("FAIL same_cycle_rd[%0d]: got %h/%h required %h", k, rd1[k], rd2[k], SAME_EXP);
      else n_pass++;
    end
    tick();
    idle();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (rd1[k] !== 64'h22) $display("FAIL same_cycle_after[%0d]: got %h required 22", k, rd1[k]);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_reset_midclear();
    int first [3];
    idle();
    for (int k = 0; k < 3; k++) begin
      we[k] = 1'b1;
      wa[k] = 5'd3;
      wd[k] = 64'h5;
    end
    tick();
    idle();
    for (int k = 0; k < 3; k++) ra1[k] = 5'd3;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (rd1[k] !== 64'h5) $display("FAIL midclear_pre_r3[%0d]: got %h required 5", k, rd1[k]);
      else n_pass++;
    end
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    tick();
    idle();
    repeat (10) tick();
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 3; k++) first[k] = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      for (int k = 0; k < 3; k++)
        if (rdy[k] === 1'b1 && first[k] < 0) first[k] = n;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (first[k] != depth[k]) $display("FAIL midclear_latency[%0d]: got %0d required %0d", k, first[k], depth[k]);
      else n_pass++;
      n_chk++;
      if (rd1[k] !== 64'h0) $display("FAIL midclear_r3[%0d]: got %h required 0", k, rd1[k]);
      else n_pass++;
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        rst[k] = ($urandom % 150) == 0;
        we[k]  = $urandom % 2;
        wa[k]  = 5'($urandom % depth[k]);
        wd[k]  = {$urandom, $urandom};
        ra1[k] = 5'($urandom % depth[k]);
        ra2[k] = 5'($urandom % depth[k]);
        if ($urandom % 4 == 0) ra1[k] = wa[k];
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (rd1[k] !== exp_rd(k, ra1[k]))
          $display("FAIL rand_rd1[%0d] cycle %0d addr %0d: got %h required %h", k, c, ra1[k], rd1[k], exp_rd(k, ra1[k]));
        else n_pass++;
        n_chk++;
        if (rd2[k] !== exp_rd(k, ra2[k]))
          $display("FAIL rand_rd2[%0d] cycle %0d addr %0d: got %h required %h", k, c, ra2[k], rd2[k], exp_rd(k, ra2[k]));
        else n_pass++;
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (rdy[k] !== e_ready(k) || drp[k] !== e_drop[k])
          $display("FAIL rand_status[%0d] cycle %0d: ready/dropped got %b/%b required %b/%b",
                   k, c, rdy[k], drp[k], e_ready(k), e_drop[k]);
        else n_pass++;
      end
    end
    idle();
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1;
      we[k]  = 1'b0;
      wa[k]  = 5'd0;
      wd[k]  = 64'h0;
      ra1[k] = 5'd0;
      ra2[k] = 5'd0;
      cnt[k] = 0;
      e_drop[k] = 1'b0;
      for (int a = 0; a < 32; a++) m[k][a] = 64'h0;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_clear_sequence();
    test_basic();
    test_zero_reg();
    test_init_drop();
    test_same_cycle();
    test_reset_midclear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
